// File: rtl/nes_mem_sched.sv
// -----------------------------------------------------------------------------
// nes_mem_sched
// Shares one SDRAM request port between the ROM loader and the NES core.
//  - A free-running 2-bit phase counter defines 4-clk NES slots; run_nes is the
//    NES clock enable (phase 3) and clkref = phase[1] is the SDRAM reference.
//  - Loader bytes arrive in bursts (ldr_wr pulses) and are queued in a small
//    FIFO, then issued one byte per slot from a slot register that holds the
//    SDRAM write for exactly one full slot (4 clks).
//  - While the loader owns the port (ldr_busy) NES requests are ignored;
//    otherwise the NES request signals pass straight through.
//
// Ports:
//  clk, reset                 clock, asynchronous active-high reset
//  downloading                loader download in progress
//  ldr_wr/ldr_addr/ldr_data   loader byte write (one-clk pulse)
//  cpu_addr/cpu_wr/cpu_dout   NES address / write request / write data
//  cpu_rd, ppu_rd             NES CPU and PPU read requests
//  phase, run_nes, clkref     slot timing outputs
//  mem_addr/mem_we/mem_din    SDRAM address / write / write data
//  mem_oeA, mem_oeB           SDRAM port A (CPU) / port B (PPU) reads
//  ldr_busy                   loader currently owns the SDRAM port
//  ldr_ovf                    sticky loader FIFO overflow flag
// -----------------------------------------------------------------------------
module nes_mem_sched #(
  parameter int ADDR_W  = 22,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              downloading,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_rd,
  input  logic              ppu_rd,
  output logic [1:0]        phase,
  output logic              run_nes,
  output logic              clkref,
  output logic [ADDR_W+2:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  output logic              mem_oeA,
  output logic              mem_oeB,
  output logic              ldr_busy,
  output logic              ldr_ovf
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [1:0]         phase_r;
  logic [FIFO_AW:0]   wr_ptr_r;
  logic [FIFO_AW:0]   rd_ptr_r;
  logic [ADDR_W-1:0]  fifo_addr_r [DEPTH];
  logic [7:0]         fifo_data_r [DEPTH];
  logic               slot_we_r;
  logic [ADDR_W-1:0]  slot_addr_r;
  logic [7:0]         slot_data_r;
  logic               ovf_r;
  logic               dl_q_r;

  logic               slot_edge_s;
  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               dl_rise_s;

  // FIFO status, pop/push qualification and download edge detect
  always_comb begin
    slot_edge_s = (phase_r == 2'd3);
    empty_s     = (wr_ptr_r == rd_ptr_r);
    // Full when the wrap bits differ but the index bits match.
    full_s      = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                  (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    pop_s       = slot_edge_s && !empty_s;
    // A same-clock pop frees a slot, so a push onto a full FIFO is still taken.
    push_s      = ldr_wr && (!full_s || pop_s);
    drop_s      = ldr_wr && full_s && !pop_s;
    dl_rise_s   = downloading && !dl_q_r;
  end

  // Slot phase counter, wraps 3 -> 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= 2'd0;
    end else begin
      phase_r <= phase_r + 2'd1;
    end
  end

  // FIFO storage and write pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
        fifo_data_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      fifo_addr_r[wr_ptr_r[FIFO_AW-1:0]] <= ldr_addr;
      fifo_data_r[wr_ptr_r[FIFO_AW-1:0]] <= ldr_data;
      wr_ptr_r <= wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer and slot register; both only move on the phase-3 clock so a
  // loader byte drives the SDRAM write for one whole slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r    <= '0;
      slot_we_r   <= 1'b0;
      slot_addr_r <= '0;
      slot_data_r <= 8'h00;
    end else if (slot_edge_s) begin
      if (!empty_s) begin
        slot_addr_r <= fifo_addr_r[rd_ptr_r[FIFO_AW-1:0]];
        slot_data_r <= fifo_data_r[rd_ptr_r[FIFO_AW-1:0]];
        slot_we_r   <= 1'b1;
        rd_ptr_r    <= rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
        slot_we_r   <= 1'b0;
      end
    end else begin
      slot_we_r <= slot_we_r;
    end
  end

  // Sticky overflow flag, cleared by a new download starting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_q_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      dl_q_r <= downloading;
      // A byte dropped in the same clock as a new download still counts.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (dl_rise_s) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Timing outputs and ownership of the SDRAM port
  always_comb begin
    phase    = phase_r;
    run_nes  = (phase_r == 2'd3);
    clkref   = phase_r[1];
    ldr_ovf  = ovf_r;
    ldr_busy = downloading | !empty_s | slot_we_r;
  end

  // SDRAM request mux; NES requests are dropped while the loader owns the port
  always_comb begin
    if (ldr_busy) begin
      mem_addr = {3'b000, slot_addr_r};
      mem_din  = slot_data_r;
      mem_we   = slot_we_r;
      mem_oeA  = 1'b0;
      mem_oeB  = 1'b0;
    end else begin
      mem_addr = {3'b000, cpu_addr};
      mem_din  = cpu_dout;
      mem_we   = cpu_wr;
      mem_oeA  = cpu_rd;
      mem_oeB  = ppu_rd;
    end
  end

endmodule

// File: tb/tb_nes_mem_sched.sv
// -----------------------------------------------------------------------------
// tb_nes_mem_sched
// Directed bench for nes_mem_sched: slot timing after reset, single loader
// byte, FIFO fill with push-on-full at phase 3 and overflow, drain after
// downloading falls, overflow clear on a new download, and reset mid-drain.
// Outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_nes_mem_sched;

  logic        clk;
  logic        reset;
  logic        downloading;
  logic        ldr_wr;
  logic [21:0] ldr_addr;
  logic [7:0]  ldr_data;
  logic [21:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic        cpu_rd;
  logic        ppu_rd;
  logic [1:0]  phase;
  logic        run_nes;
  logic        clkref;
  logic [24:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic        mem_oeA;
  logic        mem_oeB;
  logic        ldr_busy;
  logic        ldr_ovf;

  int n_checks;
  int n_fails;

  nes_mem_sched #(.ADDR_W(22), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .downloading(downloading),
    .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_rd(cpu_rd), .ppu_rd(ppu_rd),
    .phase(phase), .run_nes(run_nes), .clkref(clkref),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_oeA(mem_oeA), .mem_oeB(mem_oeB),
    .ldr_busy(ldr_busy), .ldr_ovf(ldr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    reset       = 1'b1;
    downloading = 1'b0;
    ldr_wr      = 1'b0;
    ldr_addr    = 22'h000000;
    ldr_data    = 8'h00;
    cpu_addr    = 22'h012345;
    cpu_wr      = 1'b1;
    cpu_dout    = 8'h3C;
    cpu_rd      = 1'b1;
    ppu_rd      = 1'b1;

    // ---- reset release, idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_phase",   32'(phase),    32'd0);
    chk("rst_run_nes", 32'(run_nes),  32'd0);
    chk("rst_clkref",  32'(clkref),   32'd0);
    chk("rst_busy",    32'(ldr_busy), 32'd0);
    chk("rst_ovf",     32'(ldr_ovf),  32'd0);
    chk("rst_addr",    32'(mem_addr), 32'h0012345);
    chk("rst_din",     32'(mem_din),  32'h3C);
    chk("rst_we",      32'(mem_we),   32'd1);
    chk("rst_oeA",     32'(mem_oeA),  32'd1);
    chk("rst_oeB",     32'(mem_oeB),  32'd1);

    // phases 1,2,3,0 -> run_nes 0,0,1,0 ; clkref 0,1,1,0
    step(); chk("ph1", 32'(phase), 32'd1); chk("rn1", 32'(run_nes), 32'd0); chk("cr1", 32'(clkref), 32'd0);
    step(); chk("ph2", 32'(phase), 32'd2); chk("rn2", 32'(run_nes), 32'd0); chk("cr2", 32'(clkref), 32'd1);
    step(); chk("ph3", 32'(phase), 32'd3); chk("rn3", 32'(run_nes), 32'd1); chk("cr3", 32'(clkref), 32'd1);
    step(); chk("ph0", 32'(phase), 32'd0); chk("rn0", 32'(run_nes), 32'd0); chk("cr0", 32'(clkref), 32'd0);

    // ---- single loader byte pushed at phase 0
    downloading = 1'b1;
    ldr_wr      = 1'b1;
    ldr_addr    = 22'h000010;
    ldr_data    = 8'hA5;
    #1;
    chk("one_busy", 32'(ldr_busy), 32'd1);
    chk("one_oeA0", 32'(mem_oeA),  32'd0);
    chk("one_we0",  32'(mem_we),   32'd0);
    step();
    ldr_wr = 1'b0;
    chk("one_we_p1", 32'(mem_we), 32'd0);
    step(); chk("one_we_p2", 32'(mem_we), 32'd0);
    step(); chk("one_we_p3", 32'(mem_we), 32'd0);
    step();
    chk("one_phase", 32'(phase),    32'd0);
    chk("one_we",    32'(mem_we),   32'd1);
    chk("one_addr",  32'(mem_addr), 32'h0000010);
    chk("one_din",   32'(mem_din),  32'hA5);
    chk("one_oeB",   32'(mem_oeB),  32'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("one_hold_we", 32'(mem_we), 32'd1);
      chk("one_hold_oeA", 32'(mem_oeA), 32'd0);
    end
    step();
    chk("one_end_we", 32'(mem_we), 32'd0);
    chk("one_end_busy", 32'(ldr_busy), 32'd1);

    // ---- burst of 6 starting on a phase-3 edge with an empty FIFO:
    // push 5 lands on a full FIFO with a same-clock pop (accepted),
    // push 6 lands on a full FIFO without a pop (dropped)
    repeat (3) step();
    chk("burst_start_ph", 32'(phase), 32'd3);
    for (int i = 1; i <= 6; i++) begin
      ldr_addr = 22'h000100 + 22'(i);
      ldr_data = 8'(i);
      ldr_wr   = 1'b1;
      step();
      if (i == 1) begin
        chk("b1_we",  32'(mem_we),  32'd0);
        chk("b1_ovf", 32'(ldr_ovf), 32'd0);
      end else if (i == 5) begin
        chk("b5_we",   32'(mem_we),   32'd1);
        chk("b5_din",  32'(mem_din),  32'h01);
        chk("b5_addr", 32'(mem_addr), 32'h0000101);
        chk("b5_ovf",  32'(ldr_ovf),  32'd0);
      end else if (i == 6) begin
        chk("b6_ovf", 32'(ldr_ovf), 32'd1);
        chk("b6_din", 32'(mem_din), 32'h01);
      end
    end
    ldr_wr = 1'b0;
    step(); step();
    chk("slot1_hold_din", 32'(mem_din), 32'h01);
    step();
    chk("slot2_din",  32'(mem_din),  32'h02);
    chk("slot2_addr", 32'(mem_addr), 32'h0000102);

    // ---- downloading falls with 3 bytes still queued
    downloading = 1'b0;
    #1;
    chk("fall_busy", 32'(ldr_busy), 32'd1);
    chk("fall_oeA",  32'(mem_oeA),  32'd0);
    chk("fall_ovf",  32'(ldr_ovf),  32'd1);
    for (int k = 3; k <= 5; k++) begin
      repeat (4) step();
      chk("drain_din",  32'(mem_din),  32'(k));
      chk("drain_we",   32'(mem_we),   32'd1);
      chk("drain_busy", 32'(ldr_busy), 32'd1);
      chk("drain_oeA",  32'(mem_oeA),  32'd0);
    end
    repeat (3) step();
    chk("last_slot_busy", 32'(ldr_busy), 32'd1);
    chk("last_slot_oeA",  32'(mem_oeA),  32'd0);
    step();
    chk("resume_busy", 32'(ldr_busy), 32'd0);
    chk("resume_oeA",  32'(mem_oeA),  32'd1);
    chk("resume_we",   32'(mem_we),   32'd1);
    chk("resume_addr", 32'(mem_addr), 32'h0012345);
    chk("resume_din",  32'(mem_din),  32'h3C);
    chk("resume_ovf",  32'(ldr_ovf),  32'd1);

    // ---- new download clears the overflow flag
    downloading = 1'b1;
    step();
    chk("ovf_clear", 32'(ldr_ovf), 32'd0);
    chk("ovf_clear_ph", 32'(phase), 32'd1);

    // ---- queue three bytes (phase 1,2,3 edges), then reset mid-drain
    for (int j = 0; j < 3; j++) begin
      ldr_addr = 22'h000200 + 22'(j);
      ldr_data = 8'hB1 + 8'(j);
      ldr_wr   = 1'b1;
      step();
    end
    ldr_wr = 1'b0;
    chk("mid_we",  32'(mem_we),  32'd1);
    chk("mid_din", 32'(mem_din), 32'hB1);
    #2 reset = 1'b1;
    #1;
    chk("arst_phase", 32'(phase),    32'd0);
    chk("arst_we",    32'(mem_we),   32'd0);
    chk("arst_busy",  32'(ldr_busy), 32'd1);
    chk("arst_rn",    32'(run_nes),  32'd0);
    chk("arst_cr",    32'(clkref),   32'd0);
    downloading = 1'b0;
    #1;
    chk("arst_idle_busy", 32'(ldr_busy), 32'd0);
    chk("arst_idle_we",   32'(mem_we),   32'd1);
    chk("arst_idle_oeA",  32'(mem_oeA),  32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) cpu_wr = 1'b0;
      step();
      chk("post_we",   32'(mem_we),   32'(cpu_wr));
      chk("post_busy", 32'(ldr_busy), 32'd0);
      chk("post_din",  32'(mem_din),  32'h3C);
    end

    // ---- loader write with downloading low still takes the port
    ldr_addr = 22'h000300;
    ldr_data = 8'h77;
    ldr_wr   = 1'b1;
    step();
    ldr_wr = 1'b0;
    chk("late_wr_busy", 32'(ldr_busy), 32'd1);
    chk("late_wr_oeA",  32'(mem_oeA),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
